// File: rtl/hex_display_scanner_if.sv
// Host-to-display load channel: valid/ready handshake carrying a packed
// nibble-per-digit display value.
interface hex_display_scanner_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic                      load_valid;
    logic [4*NUM_DIGITS-1:0]   load_value;
    logic                      load_ready;

    modport master (output load_valid, output load_value, input load_ready);
    modport slave  (input load_valid, input load_value, output load_ready);
endinterface

// File: rtl/hex_display_scanner.sv
// Time-multiplexed common-anode 7-segment scanner. Each digit is driven for
// SCAN_DIV cycles followed by GAP_CYCLES of all-anodes-off. New values are
// double-buffered and committed only at the frame boundary (no tearing).
// Optional: define HEX_DISPLAY_LZ_SUPPRESS_EN to blank leading zero digits.
module hex_display_scanner #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SEL_W      = 2,
    parameter int unsigned SCAN_DIV   = 1024,
    parameter int unsigned GAP_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    hex_display_scanner_if.slave  load,
    input  logic [NUM_DIGITS-1:0] blank,
    output logic [6:0]            seg_out,
    output logic [NUM_DIGITS-1:0] an_out,
    output logic                  frame_tick
);

    localparam logic [0:0] DRIVE = 1'b0;
    localparam logic [0:0] GAP   = 1'b1;

    logic [0:0]              state;
    logic [SEL_W-1:0]        digit;
    logic [15:0]             cnt;
    logic [4*NUM_DIGITS-1:0] active;
    logic [4*NUM_DIGITS-1:0] pending;
    logic                    pending_full;

    logic                    drive_last;
    logic                    gap_last;
    logic                    last_digit;
    logic                    boundary;
    logic [3:0]              cur_nibble;
    logic                    cur_blank;
    logic [NUM_DIGITS-1:0]   lz_mask;

    assign load.load_ready = ~pending_full;

    assign drive_last = (cnt == 16'(SCAN_DIV - 1));
    assign gap_last   = (cnt == 16'(GAP_CYCLES - 1));
    assign last_digit = (digit == SEL_W'(NUM_DIGITS - 1));
    assign boundary   = (state == GAP) && gap_last && last_digit;

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Leading-zero mask from the committed value; digit 0 is never masked.
`ifdef HEX_DISPLAY_LZ_SUPPRESS_EN
    logic higher_nz;
    always_comb begin
        lz_mask   = '0;
        higher_nz = 1'b0;
        for (int unsigned i = NUM_DIGITS - 1; i > 0; i--) begin
            if (active[4*i +: 4] != 4'h0) higher_nz = 1'b1;
            lz_mask[i] = ~higher_nz;
        end
    end
`else
    always_comb begin
        lz_mask = '0;
    end
`endif

    // Select the current digit's nibble and its blanking condition.
    always_comb begin
        cur_nibble = '0;
        cur_blank  = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (digit == SEL_W'(i)) begin
                cur_nibble = active[4*i +: 4];
                cur_blank  = blank[i] | lz_mask[i];
            end
        end
    end

    // Scan FSM: DRIVE for SCAN_DIV cycles, GAP for GAP_CYCLES, then next digit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= DRIVE;
            digit <= '0;
            cnt   <= '0;
        end else if (state == DRIVE) begin
            if (drive_last) begin
                state <= GAP;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end else begin
            if (gap_last) begin
                state <= DRIVE;
                cnt   <= '0;
                digit <= last_digit ? '0 : digit + 1'b1;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

    // Load buffer: commit at the frame boundary takes priority over capture,
    // so a load accepted on the boundary edge waits for the next boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active       <= '0;
            pending      <= '0;
            pending_full <= 1'b0;
        end else if (boundary && pending_full) begin
            active       <= pending;
            pending_full <= 1'b0;
        end else if (load.load_valid && !pending_full) begin
            pending      <= load.load_value;
            pending_full <= 1'b1;
        end
    end

    // Registered outputs reflecting the previous cycle's scan state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_out    <= 7'b1111111;
            an_out     <= '1;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= (state == DRIVE) && (digit == '0) && (cnt == '0);
            if (state == DRIVE && !cur_blank) begin
                seg_out <= decode(cur_nibble);
                an_out  <= ~(NUM_DIGITS'(1) << digit);
            end else begin
                seg_out <= 7'b1111111;
                an_out  <= '1;
            end
        end
    end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed bench for hex_display_scanner (NUM_DIGITS=4, SCAN_DIV=4,
// GAP_CYCLES=2). A frame-position model pushes expected outputs to a
// scoreboard before each edge; they are popped and compared after it.
module tb_hex_display_scanner;

    localparam int FRAME = 24;
    localparam int SLOT  = 6;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       tick;
        logic       ready;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] blank = 4'b0000;
    logic [6:0] seg_out;
    logic [3:0] an_out;
    logic       frame_tick;

    hex_display_scanner_if #(.NUM_DIGITS(4)) bus ();

    hex_display_scanner #(
        .NUM_DIGITS(4),
        .SEL_W(2),
        .SCAN_DIV(4),
        .GAP_CYCLES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .load(bus.slave),
        .blank(blank),
        .seg_out(seg_out),
        .an_out(an_out),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          e = 0;
    logic [15:0] m_active = 16'h0;
    logic [15:0] m_pend = 16'h0;
    logic        m_full = 1'b0;
    bit          accepted = 1'b0;
    exp_t        sb[$];

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
            4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
            4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
            4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    function automatic bit lz(input logic [15:0] v, input int d);
`ifdef HEX_DISPLAY_LZ_SUPPRESS_EN
        logic [15:0] sh;
        sh = v >> (4 * d);
        return (d != 0) && (sh == 16'h0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        exp_t        x;
        exp_t        y;
        int          p, s, o;
        logic [15:0] v;
        p = e % FRAME;
        s = p / SLOT;
        o = p % SLOT;
        v = m_active >> (4 * s);
        if (o < 4 && !(blank[s] || lz(m_active, s))) begin
            x.an  = ~(4'b0001 << s);
            x.seg = seg_of(v[3:0]);
        end else begin
            x.an  = 4'b1111;
            x.seg = 7'h7F;
        end
        x.tick = (p == 0);
        if (p == FRAME - 1 && m_full) begin
            m_active = m_pend;
            m_full   = 1'b0;
        end else if (bus.load_valid && !m_full) begin
            m_pend   = bus.load_value;
            m_full   = 1'b1;
            accepted = 1'b1;
        end
        x.ready = !m_full;
        sb.push_back(x);
        @(posedge clk);
        #1;
        e++;
        y = sb.pop_front();
        chk("an_out", 32'(an_out), 32'(y.an));
        chk("seg_out", 32'(seg_out), 32'(y.seg));
        chk("frame_tick", 32'(frame_tick), 32'(y.tick));
        chk("load_ready", 32'(bus.load_ready), 32'(y.ready));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_to(input int pos);
        for (int i = 0; i < FRAME && (e % FRAME) != pos; i++) step();
    endtask

    task automatic offer(input logic [15:0] v);
        bus.load_valid = 1'b1;
        bus.load_value = v;
        accepted = 1'b0;
        for (int n = 0; n < 100 && !accepted; n++) step();
        chk("load_accept", 32'(accepted), 32'd1);
        bus.load_valid = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_seg"}, 32'(seg_out), 32'h7F);
        chk({tag, "_an"}, 32'(an_out), 32'hF);
        chk({tag, "_ready"}, 32'(bus.load_ready), 32'd1);
        chk({tag, "_tick"}, 32'(frame_tick), 32'd0);
    endtask

    initial begin
        bus.load_valid = 1'b0;
        bus.load_value = 16'h0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        reset = 1'b0;
        e = 0;

        // Free run showing 0000
        run(2 * FRAME);

        // Mid-frame load, then a second load offered while pending
        run_to(8);
        offer(16'h1A3F);
        offer(16'h5555);
        run(2 * FRAME + 4);

        // Per-digit blank with 8888
        blank = 4'b0100;
        offer(16'h8888);
        run(2 * FRAME);
        blank = 4'b0000;

        // Reset during the digit-2 slot with a pending load
        run_to(12);
        offer(16'h7777);
        reset = 1'b1;
        #1;
        chk_reset_vals("midreset");
        @(posedge clk);
        #1;
        chk_reset_vals("midreset_hold");
        reset = 1'b0;
        e = 0;
        m_active = 16'h0;
        m_full = 1'b0;
        run(2 * FRAME + 3);

        // Leading-zero cases (suppressed only when the macro is defined)
        offer(16'h0050);
        run(2 * FRAME);
        offer(16'h0000);
        run(2 * FRAME);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
